// File: rtl/mod_keystore_if.sv
// Bus bundle for the AES round-key store: write/read strobes in, read data and status out.
interface mod_keystore_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    logic              clr_keyStore;
    logic [1:0]        mode_keyStore;
    logic [DATA_W-1:0] inp_keyStore;
    logic              wrEn_keyStore;
    logic              rdEn_keyStore;
    logic [ADDR_W-1:0] addr_keyStore;
    logic              dir_keyStore;
    logic [DATA_W-1:0] outp_keyStore;
    logic              outp_valid;
    logic              full_keyStore;
    logic [ADDR_W-1:0] key_cnt;
    logic [1:0]        err_keyStore;

    modport master (
        output clr_keyStore, mode_keyStore, inp_keyStore, wrEn_keyStore,
               rdEn_keyStore, addr_keyStore, dir_keyStore,
        input  outp_keyStore, outp_valid, full_keyStore, key_cnt, err_keyStore
    );

    modport slave (
        input  clr_keyStore, mode_keyStore, inp_keyStore, wrEn_keyStore,
               rdEn_keyStore, addr_keyStore, dir_keyStore,
        output outp_keyStore, outp_valid, full_keyStore, key_cnt, err_keyStore
    );
endinterface

// File: rtl/mod_keystore.sv
// AES round-key store: sequential fill of up to NK keys, 1-cycle reads in
// forward or reversed (decrypt) order, sticky overflow / invalid-read flags.
module mod_keystore #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    mod_keystore_if.slave  ks
);

    logic [1:0]        mode_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] outp_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] slot_reg [DEPTH];

    logic [1:0]        mode_eff;
    logic [ADDR_W-1:0] nk;
    logic              wr_ok;
    logic              wr_ovf;
    logic [ADDR_W-1:0] rd_slot;
    logic              rd_bad;
    logic [DEPTH-1:0]  slot_we;

    function automatic logic [ADDR_W-1:0] nk_of(input logic [1:0] m);
        case (m)
            2'd0:    return ADDR_W'(11);
            2'd1:    return ADDR_W'(13);
            default: return ADDR_W'(15);
        endcase
    endfunction

    // Until the first key lands the live mode decides NK; afterwards the latched one does.
    assign mode_eff = (cnt_reg == '0) ? ks.mode_keyStore : mode_reg;
    assign nk       = nk_of(mode_eff);

    assign wr_ok  = ks.wrEn_keyStore && !ks.clr_keyStore && (cnt_reg < nk);
    assign wr_ovf = ks.wrEn_keyStore && !ks.clr_keyStore && !(cnt_reg < nk);

    // Decrypt order mirrors the index; out-of-range addresses wrap but are masked by rd_bad.
    assign rd_slot = ks.dir_keyStore ? (nk - ADDR_W'(1) - ks.addr_keyStore) : ks.addr_keyStore;
    assign rd_bad  = (ks.addr_keyStore >= nk) || (rd_slot >= cnt_reg);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = wr_ok && (cnt_reg == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_we[i]) begin
                    slot_reg[i] <= ks.inp_keyStore;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            mode_reg  <= '0;
            err_reg   <= '0;
            outp_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (ks.clr_keyStore) begin
            cnt_reg   <= '0;
            mode_reg  <= '0;
            err_reg   <= '0;
            outp_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= ks.rdEn_keyStore;
            // Read sees pre-write state, so a same-slot write is reported invalid.
            if (ks.rdEn_keyStore) begin
                outp_reg <= rd_bad ? '0 : slot_reg[rd_slot];
                if (rd_bad) begin
                    err_reg[1] <= 1'b1;
                end
            end
            if (wr_ovf) begin
                err_reg[0] <= 1'b1;
            end
            if (wr_ok) begin
                cnt_reg <= cnt_reg + ADDR_W'(1);
                if (cnt_reg == '0) begin
                    mode_reg <= ks.mode_keyStore;
                end
            end
        end
    end

    assign ks.outp_keyStore = outp_reg;
    assign ks.outp_valid    = valid_reg;
    assign ks.key_cnt       = cnt_reg;
    assign ks.err_keyStore  = err_reg;
    assign ks.full_keyStore = (cnt_reg == nk);

endmodule
